// File: rtl/vend_sequencer_if.sv
// rtl/vend_sequencer_if.sv - request/strobe/change bundle between vend_sequencer and its environment
//
// master : environment side (drives requests, balance, dispenser ready; observes strobes)
// slave  : vend_sequencer side
// Signals:
//   power_on, coin_req[2:0], sel_req[1:0], finish, left[7:0], overflow, change_ready  (to sequencer)
//   state[1:0], coin[2:0], ab[1:0], change_valid, change_half, busy                  (from sequencer)
interface vend_sequencer_if;
    logic       power_on;
    logic [2:0] coin_req;
    logic [1:0] sel_req;
    logic       finish;
    logic [7:0] left;
    logic       overflow;
    logic       change_ready;
    logic [1:0] state;
    logic [2:0] coin;
    logic [1:0] ab;
    logic       change_valid;
    logic       change_half;
    logic       busy;

    modport master (
        output power_on, coin_req, sel_req, finish, left, overflow, change_ready,
        input  state, coin, ab, change_valid, change_half, busy
    );

    modport slave (
        input  power_on, coin_req, sel_req, finish, left, overflow, change_ready,
        output state, coin, ab, change_valid, change_half, busy
    );
endinterface

// File: rtl/vend_sequencer.sv
// rtl/vend_sequencer.sv - vending machine control FSM: request queueing, strobe issue, change payout
//
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous active-low reset
//   bus    : vend_sequencer_if.slave (requests in, datapath mode/strobes and change handshake out)
// Parameter TIMEOUT_CYC : idle SELL cycles before change is forced.
// Macro VEND_TIMEOUT_EN : when defined, the SELL idle timeout is built in; otherwise SELL
//                         leaves only via finish or power_on=0.
module vend_sequencer #(
    parameter logic [31:0] TIMEOUT_CYC = 32'd1000
) (
    input  logic            clk,
    input  logic            reset,
    vend_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        S_OFF    = 2'b00,
        S_INIT   = 2'b01,
        S_SELL   = 2'b10,
        S_CHANGE = 2'b11
    } state_t;

    state_t     state_q;
    logic [4:0] pend_q;     // {coin2, coin1, coin0, ab1, ab0}, MSB = highest priority
    logic [2:0] coin_q;
    logic [1:0] ab_q;
    logic       gap_q;      // cycle following a strobe
    logic       fin_q;      // finish seen while requests still draining
    logic [7:0] chg_q;      // remaining change, 0.5-yuan units
`ifdef VEND_TIMEOUT_EN
    logic [31:0] tmo_q;
`endif

    logic [4:0] req_vec;
    logic [4:0] req_new;
    logic [4:0] issue;
    logic       in_sell;
    logic       stb_on;
    logic       tmo_hit;
    logic       fin_any;
    logic       go_change;
    logic [7:0] chg_dec;

    always_comb begin
        req_vec = {bus.coin_req, bus.sel_req};
        in_sell = (state_q == S_SELL);
        stb_on  = (coin_q != 3'b000) || (ab_q != 2'b00);
        // Requests for bits already pending are absorbed.
        req_new = in_sell ? (req_vec & ~pend_q) : 5'b00000;
        issue   = 5'b00000;
        if (in_sell && !stb_on) begin
            casez (pend_q)
                5'b1????: issue = 5'b10000;
                5'b01???: issue = 5'b01000;
                5'b001??: issue = 5'b00100;
                5'b0001?: issue = 5'b00010;
                5'b00001: issue = 5'b00001;
                default:  issue = 5'b00000;
            endcase
        end
`ifdef VEND_TIMEOUT_EN
        tmo_hit = in_sell && (tmo_q == TIMEOUT_CYC - 32'd1);
`else
        tmo_hit = 1'b0;
`endif
        fin_any = fin_q | bus.finish | tmo_hit;
        // Leave SELL only once nothing is queued, nothing new arrives and no strobe is high;
        // a strobe cycle is always followed by its gap before this can be true.
        go_change = in_sell && fin_any && (pend_q == 5'b00000) && (req_vec == 5'b00000) && !stb_on;
        chg_dec   = (chg_q == 8'd1) ? 8'd1 : 8'd2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OFF;
            pend_q  <= '0;
            coin_q  <= '0;
            ab_q    <= '0;
            gap_q   <= 1'b0;
            fin_q   <= 1'b0;
            chg_q   <= '0;
`ifdef VEND_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else if (!bus.power_on) begin
            state_q <= S_OFF;
            pend_q  <= '0;
            coin_q  <= '0;
            ab_q    <= '0;
            gap_q   <= 1'b0;
            fin_q   <= 1'b0;
            chg_q   <= '0;
`ifdef VEND_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_OFF: state_q <= S_INIT;
                S_INIT: begin
                    state_q <= S_SELL;
                    fin_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                S_SELL: begin
                    pend_q <= (pend_q & ~issue) | req_new;
                    coin_q <= issue[4:2];
                    ab_q   <= issue[1:0];
                    gap_q  <= stb_on;
                    if (go_change) begin
                        state_q <= S_CHANGE;
                        chg_q   <= bus.left;
                        fin_q   <= 1'b0;
                    end else begin
                        fin_q   <= fin_any;
                    end
`ifdef VEND_TIMEOUT_EN
                    if ((req_vec != 5'b00000) || bus.finish)
                        tmo_q <= '0;
                    else if (tmo_q != 32'hFFFF_FFFF)
                        tmo_q <= tmo_q + 32'd1;
`endif
                end
                S_CHANGE: begin
                    coin_q <= '0;
                    ab_q   <= '0;
                    gap_q  <= 1'b0;
                    if (chg_q == 8'd0)
                        state_q <= S_INIT;
                    else if (bus.change_ready)
                        chg_q <= chg_q - chg_dec;
                end
                default: state_q <= S_OFF;
            endcase
        end
    end

    assign bus.state        = state_q;
    assign bus.coin         = coin_q;
    assign bus.ab           = ab_q;
    assign bus.change_valid = (state_q == S_CHANGE) && (chg_q != 8'd0);
    assign bus.change_half  = (state_q == S_CHANGE) && (chg_q == 8'd1);
    assign bus.busy         = (pend_q != 5'b00000) || stb_on || gap_q;
endmodule

// File: tb/tb_vend_sequencer.sv
// tb/tb_vend_sequencer.sv - self-checking bench for vend_sequencer
module tb_vend_sequencer;
    localparam int TMO = 8;
`ifdef VEND_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    vend_sequencer_if bif();

    vend_sequencer #(.TIMEOUT_CYC(32'd8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: machine mode, pending set, current strobe index, balance in half-yuan.
    int m_mode;
    int m_stb;      // index 4..0 of strobe high this cycle, -1 when none
    int m_gap;
    int m_fin;
    int m_bal;
    int m_idle;
    int m_pend[5];

    task automatic m_reset();
        m_mode = 0; m_stb = -1; m_gap = 0; m_fin = 0; m_bal = 0; m_idle = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic m_edge();
        int  reqs[5];
        int  old[5];
        bit  any_req, any_pend, strobing, fin_any;
        int  pick;
        reqs[4] = bif.coin_req[2]; reqs[3] = bif.coin_req[1]; reqs[2] = bif.coin_req[0];
        reqs[1] = bif.sel_req[1];  reqs[0] = bif.sel_req[0];
        if (!bif.power_on) begin
            m_reset();
            return;
        end
        case (m_mode)
            0: m_mode = 1;
            1: begin m_mode = 2; m_idle = 0; m_fin = 0; end
            2: begin
                any_req = 0; any_pend = 0;
                for (int i = 0; i < 5; i++) begin
                    any_req  |= (reqs[i] != 0);
                    any_pend |= (m_pend[i] != 0);
                    old[i] = m_pend[i];
                end
                strobing = (m_stb >= 0);
                pick = -1;
                if (!strobing)
                    for (int i = 4; i >= 0; i--)
                        if (m_pend[i] != 0 && pick < 0) pick = i;
                fin_any = (m_fin != 0) || bif.finish || (TMO_EN && m_idle == TMO - 1);
                m_gap = strobing;
                m_stb = pick;
                if (pick >= 0) m_pend[pick] = 0;
                for (int i = 0; i < 5; i++)
                    if (reqs[i] != 0 && old[i] == 0) m_pend[i] = 1;
                if (fin_any && !any_pend && !any_req && !strobing) begin
                    m_mode = 3; m_bal = int'(bif.left); m_fin = 0;
                end else begin
                    m_fin = fin_any;
                end
                if (any_req || bif.finish) m_idle = 0; else m_idle++;
            end
            default: begin
                if (m_bal == 0) m_mode = 1;
                else if (bif.change_ready) m_bal -= (m_bal == 1) ? 1 : 2;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare();
        logic [2:0] ec;
        logic [1:0] ea;
        int any_p;
        ec = (m_stb == 4) ? 3'b100 : (m_stb == 3) ? 3'b010 : (m_stb == 2) ? 3'b001 : 3'b000;
        ea = (m_stb == 1) ? 2'b10 : (m_stb == 0) ? 2'b01 : 2'b00;
        any_p = 0;
        foreach (m_pend[i]) any_p |= m_pend[i];
        chk("state", bif.state, m_mode);
        chk("coin", bif.coin, ec);
        chk("ab", bif.ab, ea);
        chk("change_valid", bif.change_valid, (m_mode == 3 && m_bal > 0) ? 1 : 0);
        chk("change_half", bif.change_half, (m_mode == 3 && m_bal == 1) ? 1 : 0);
        chk("busy", bif.busy, (any_p != 0 || m_stb >= 0 || m_gap != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_in();
        bif.coin_req = 3'b000; bif.sel_req = 2'b00; bif.finish = 1'b0;
    endtask

    // Power-cycle into a fresh SELL cycle (timeout count at zero).
    task automatic fresh_sell();
        idle_in();
        bif.change_ready = 1'b0;
        bif.power_on = 1'b0; tick();
        bif.power_on = 1'b1; tick(); tick();
        chk("fresh_sell_state", bif.state, 2'b10);
    endtask

    int exp_half[4] = '{0, 0, 0, 1};

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0;
        bif.power_on = 1'b1; bif.left = 8'd0; bif.overflow = 1'b0; bif.change_ready = 1'b0;
        idle_in();
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_state", bif.state, 2'b00);
        chk("rst_coin", bif.coin, 3'b000);
        chk("rst_ab", bif.ab, 2'b00);
        chk("rst_cv", bif.change_valid, 1'b0);
        chk("rst_ch", bif.change_half, 1'b0);
        chk("rst_busy", bif.busy, 1'b0);

        // Power-up sequence 00 -> 01 -> 10
        reset = 1'b1;
        tick(); chk("pwr_init", bif.state, 2'b01);
        tick(); chk("pwr_sell", bif.state, 2'b10);
        chk("pwr_strobe", {bif.coin, bif.ab}, 5'b00000);

        // Coin and item request in the same cycle
        fresh_sell();
        bif.coin_req = 3'b001; bif.sel_req = 2'b10; bif.overflow = 1'b1;
        tick(); idle_in(); bif.overflow = 1'b0;
        chk("s033_pend_busy", bif.busy, 1'b1);
        tick(); chk("s033_coin", bif.coin, 3'b001); chk("s033_ab0", bif.ab, 2'b00);
        tick(); chk("s033_gap1", {bif.coin, bif.ab}, 5'b00000);
        tick(); chk("s033_ab", bif.ab, 2'b10); chk("s033_coin0", bif.coin, 3'b000);
        tick(); chk("s033_gap2", {bif.coin, bif.ab}, 5'b00000); chk("s033_gapbusy", bif.busy, 1'b1);
        tick(); chk("s033_idle", bif.busy, 1'b0);

        // Change of 3.5 yuan with a stalled dispenser on the first unit
        fresh_sell();
        bif.left = 8'd7; bif.finish = 1'b1;
        tick(); idle_in();
        bif.change_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s034_hold_valid", bif.change_valid, 1'b1);
            chk("s034_hold_half", bif.change_half, 1'b0);
            tick();
        end
        bif.change_ready = 1'b1;
        for (int u = 0; u < 4; u++) begin
            chk("s034_unit_valid", bif.change_valid, 1'b1);
            chk("s034_unit_half", bif.change_half, exp_half[u]);
            tick();
        end
        chk("s034_done", bif.change_valid, 1'b0);
        tick(); chk("s034_init", bif.state, 2'b01);
        tick(); chk("s034_sell", bif.state, 2'b10);

        // finish together with a coin: strobe first, then CHANGE
        fresh_sell();
        bif.left = 8'd0; bif.coin_req = 3'b100; bif.finish = 1'b1;
        tick(); idle_in();
        chk("s035_still_sell", bif.state, 2'b10);
        tick(); chk("s035_coin", bif.coin, 3'b100);
        tick(); chk("s035_gap", bif.state, 2'b10);
        tick(); chk("s035_change", bif.state, 2'b11);

        // power_on dropped mid-change
        fresh_sell();
        bif.left = 8'd5; bif.finish = 1'b1;
        tick(); idle_in();
        chk("s037_valid", bif.change_valid, 1'b1);
        bif.power_on = 1'b0;
        tick();
        chk("s037_off", bif.state, 2'b00);
        chk("s037_cv", bif.change_valid, 1'b0);
        bif.power_on = 1'b1;

        // Asynchronous reset in the middle of a change
        fresh_sell();
        bif.left = 8'd3; bif.finish = 1'b1;
        tick(); idle_in();
        #2 reset = 1'b0;
        #1;
        chk("arst_state", bif.state, 2'b00);
        chk("arst_cv", bif.change_valid, 1'b0);
        chk("arst_busy", bif.busy, 1'b0);
        m_reset();
        #1 reset = 1'b1;
        tick();

`ifdef VEND_TIMEOUT_EN
        fresh_sell();
        for (int k = 0; k < 7; k++) tick();
        chk("tmo_pre", bif.state, 2'b10);
        tick(); chk("tmo_hit", bif.state, 2'b11);
        fresh_sell();
        for (int k = 0; k < 5; k++) tick();
        bif.coin_req = 3'b001; tick(); idle_in();
        for (int k = 6; k < 8; k++) tick();
        chk("tmo_restart_sell", bif.state, 2'b10);
        for (int k = 8; k < 14; k++) tick();
        chk("tmo_restart_hit", bif.state, 2'b11);
`endif

        // Randomised operation against the reference model
        for (int n = 0; n < 3000; n++) begin
            bif.power_on     = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            bif.coin_req     = ($urandom_range(0, 9) < 2) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            bif.sel_req      = ($urandom_range(0, 9) < 2) ? 2'($urandom_range(1, 3)) : 2'b00;
            bif.finish       = ($urandom_range(0, 14) == 0);
            bif.left         = 8'($urandom_range(0, 15));
            bif.change_ready = ($urandom_range(0, 9) < 7);
            bif.overflow     = 1'($urandom_range(0, 1));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vend_sequencer.md
VEND_SEQUENCER -- requirements
Module: vend_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 32'd1000, idle cycles in SELL before forced change return.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 power_on  in  1  level; machine enabled while 1.
REQ-005 coin_req  in  3  one-cycle one-hot request: bit0 1 yuan, bit1 5 yuan, bit2 10 yuan.
REQ-006 sel_req  in  2  one-cycle request: bit1 5-yuan item, bit0 2.5-yuan item.
REQ-007 finish  in  1  one-cycle customer "done / return change" request.
REQ-008 left  in  8  datapath balance, 0.5-yuan units, 0..199.
REQ-009 overflow  in  1  datapath reject flag, status only.
REQ-010 change_ready  in  1  change dispenser accepts the current unit.
REQ-011 state  out  2  datapath mode: 00 OFF, 01 INIT (datapath clears), 10 SELL, 11 CHANGE.
REQ-012 coin  out  3  one-hot coin strobe to datapath.
REQ-013 ab  out  2  item-select strobe to datapath.
REQ-014 change_valid  out  1  change unit offered.
REQ-015 change_half  out  1  with change_valid: 1 = 0.5-yuan unit, 0 = 1-yuan unit.
REQ-016 busy  out  1  high when any request is pending or a strobe is in flight.

Function
REQ-017 FSM states OFF, INIT, SELL, CHANGE; state output equals the registered FSM encoding.
REQ-018 OFF -> INIT when power_on=1; INIT lasts exactly one cycle, then SELL.
REQ-019 SELL -> CHANGE on finish or on timeout; any state -> OFF when power_on=0 (pending requests and strobes cleared, change abandoned).
REQ-020 CHANGE: on entry cycle, a 8-bit change counter loads left; CHANGE exits to INIT once the counter reaches 0 (counter 0 at entry -> INIT the next cycle).
REQ-021 Change handshake: change_valid=1 while counter>0; change_half=1 iff counter==1; on change_valid&change_ready, the counter decrements by 2 (change_half=0) or 1 (change_half=1); change_valid/change_half stay stable until accepted.
REQ-022 coin_req/sel_req are captured into pending registers (one per bit) only in SELL; they are ignored in OFF, INIT and CHANGE; a request for an already-pending bit is absorbed.
REQ-023 Strobe protocol: the issued bit is driven high for exactly one cycle, then all strobes are driven 0 for one cycle; at most one strobe bit is high in any cycle; the issue rate is one per 2 cycles.
REQ-024 Issue priority: coin bit2 > bit1 > bit0 > ab[1] > ab[0]; a pending bit clears in the cycle it is issued.
REQ-025 finish with requests pending: the transition to CHANGE is deferred until the pending set is empty and the strobe gap has completed; finish is latched meanwhile.
REQ-026 Timeout counter: it clears on entry to SELL and on any accepted coin_req/sel_req/finish, increments otherwise in SELL, and saturates; count == TIMEOUT_CYC-1 acts as a finish.
REQ-027 busy = (pending set nonzero) | strobe-high cycle | strobe-gap cycle.
REQ-028 The block does not interpret overflow; requests are forwarded regardless of its value.

Reset
REQ-029 On reset=0: state=OFF(00), coin=000, ab=00, change_valid=0, change_half=0, busy=0, pending, change and timeout counters all 0, latched finish 0.
REQ-030 A reset asserted mid-operation (strobe high or in CHANGE) takes effect immediately; no partial strobe or change unit is completed.

Configuration
REQ-031 Macro VEND_TIMEOUT_EN: when defined, REQ-026 timeout logic is present; when undefined, there is no timeout counter and SELL leaves only via finish or power_on=0.

Verification
REQ-032 Reset release, power_on=1 -> state 00,01,10 on successive cycles; all strobes 0.
REQ-033 In SELL, coin_req=001 and sel_req=10 in the same cycle -> coin=001 for 1 cycle, gap, ab=10 for 1 cycle, gap; busy falls afterwards.
REQ-034 left=7, finish -> change_valid with change_half 0,0,0,1 (4 units); change_ready held low 3 cycles on the first unit holds values stable; then INIT, SELL.
REQ-035 finish in the same cycle as coin_req=100 -> coin strobe issued first, then CHANGE.
REQ-036 With VEND_TIMEOUT_EN and TIMEOUT_CYC=8, SELL idle -> CHANGE after 8 cycles; a coin_req at cycle 5 restarts the count.
REQ-037 power_on dropped during CHANGE with counter=5 -> state 00 next cycle, change_valid=0.
